snes_multi_pad: RTL
===================

Name: snes_multi_pad

Overview:
- Parametrised multi-controller SNES pad reader: one shared latch/clock pair drives NUM_PADS controllers in parallel, each with its own serial data line.
- Clocks in BITS bits per pad every poll period and presents debounced-by-frame, active-high button words to game logic.
- Replaces the single-pad, fixed-12-bit reader with configurable timing, frame width and a frame-complete strobe.
- Sits between the controller port pins and the memory-mapped I/O/button register.

Parameters:
- NUM_PADS, 2, number of controllers sharing snes_clk/data_latch.
- BITS, 16, serial bits clocked per pad per frame (12 button bits + 4 ID bits on a standard pad).
- HALF_TICKS, 150, clk cycles per snes_clk half period (6 us at 25 MHz).
- LATCH_TICKS, 300, clk cycles data_latch held high (12 us at 25 MHz).
- POLL_TICKS, 416750, clk cycles between frame starts (~60 Hz at 25 MHz).
- CNT_W, 20, width of poll and phase counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- poll_en  in  1  enables polling; sampled only at frame start.
- serial_data  in  NUM_PADS  raw controller data lines, bit p = pad p, low = pressed.
- snes_clk  out  1  shared controller clock, idles high.
- data_latch  out  1  shared latch pulse.
- button_data  out  NUM_PADS*BITS  pad p at [p*BITS +: BITS], bit i = serial bit i, 1 = pressed.
- frame_valid  out  1  one-cycle pulse when button_data updates.
- busy  out  1  high from frame start to frame_valid inclusive.

Behaviour:
- Reset values: snes_clk=1, data_latch=0, button_data=0, frame_valid=0, busy=0, poll counter=0, state IDLE, shift registers=0.
- Poll counter counts 0..POLL_TICKS-1 and wraps, free-running. A frame starts on the cycle the counter is 0 and poll_en=1. The first frame starts on the first clk edge after reset release if poll_en=1.
- FSM IDLE: on frame start go to LATCH and clear the phase counter.
- FSM LATCH: data_latch=1 for exactly LATCH_TICKS cycles, then go to LOW with bit index 0.
- FSM LOW: snes_clk=0 for HALF_TICKS cycles. On the last LOW cycle, sample ~serial_data[p] into shift bit i for every pad. Then go to HIGH.
- FSM HIGH: snes_clk=1 for HALF_TICKS cycles. If i==BITS-1 go to DONE, else increment i and return to LOW.
- FSM DONE: one cycle. Copy all shift registers to button_data, frame_valid=1, then go to IDLE.
- Frame length: frame_valid asserts exactly LATCH_TICKS + 2*HALF_TICKS*BITS cycles after frame start.
- button_data holds between frames and never shows a partial frame.
- poll_en deasserted mid-frame: the current frame completes normally and no further frames start.
- Counter at 0 while the FSM is not IDLE: no new frame starts and none is queued.
- POLL_TICKS must exceed LATCH_TICKS + 2*HALF_TICKS*BITS + 1. This is enforced by an elaboration-time assertion, as is HALF_TICKS, LATCH_TICKS >= 1.
- Reset mid-frame: the frame is abandoned, all outputs return to reset values, and no frame_valid is issued.
- Counters are CNT_W bits unsigned with no overflow in legal configurations. serial_data is passed through a 2-flop synchroniser per pad before sampling; the sample point is the synchronised value.

Optional Feature:
- Macro SNES_EDGE_EN.
- When defined, adds output press_pulse (NUM_PADS*BITS): on the frame_valid cycle, press_pulse = new_data & ~old_button_data; it is 0 on all other cycles and 0 in reset.
- When undefined, the port and its logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package snes_pkg: button index constants B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11, and the FSM state enum (IDLE, LATCH, LOW, HIGH, DONE).
- Sub-module snes_pad_shift: one instance per pad, containing the synchroniser, BITS-wide shift/sample register and the load-on-DONE output register. The top level holds the FSM and counters.

Test Plan (HALF_TICKS=2, LATCH_TICKS=4, POLL_TICKS=100, BITS=16, NUM_PADS=2):
- Timing check:
  - Stimulus: release reset with poll_en=1.
  - Response: data_latch high cycles 0-3; snes_clk low at cycles 4-5, 8-9, …; 16 low pulses; frame_valid at cycle 68; next frame starts at cycle 100.
- Data mapping:
  - Stimulus: pad0 drives bit pattern 0xFFFE raw (B pressed), pad1 drives 0x7FFF raw (bit 15 low).
  - Response: button_data[15:0]=0x0001 and button_data[31:16]=0x8000 at frame_valid.
- Stop polling:
  - Stimulus: deassert poll_en at cycle 30 of the frame.
  - Response: frame completes with frame_valid at 68; no data_latch at 100; button_data holds.
- Reset mid-frame:
  - Stimulus: assert reset at cycle 40.
  - Response: immediately snes_clk=1, data_latch=0, button_data=0, busy=0; no frame_valid.
- Edge pulses (SNES_EDGE_EN):
  - Stimulus: A released in frame 1, pressed in frames 2 and 3.
  - Response: press_pulse bit 8 set only on frame 2's frame_valid cycle.

Source files
------------

// File: rtl/snes_pkg.sv
// Shared constants for the SNES multi-pad reader: button bit positions and FSM states.
package snes_pkg;

    localparam int B      = 0;
    localparam int Y      = 1;
    localparam int SELECT = 2;
    localparam int START  = 3;
    localparam int UP     = 4;
    localparam int DOWN   = 5;
    localparam int LEFT   = 6;
    localparam int RIGHT  = 7;
    localparam int A      = 8;
    localparam int X      = 9;
    localparam int L      = 10;
    localparam int R      = 11;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

endpackage

// File: rtl/snes_pad_shift.sv
// Per-pad datapath: 2-flop synchroniser, bit-indexed sample register, frame output register.
// SNES_EDGE_EN adds the press_pulse output (newly pressed buttons on the load cycle).
module snes_pad_shift
    import snes_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int BIT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial,
    input  logic             sample,
    input  logic [BIT_W-1:0] bit_idx,
    input  logic             load,
`ifdef SNES_EDGE_EN
    output logic [BITS-1:0]  press,
`endif
    output logic [BITS-1:0]  data
);

    logic [1:0]      sync_q;
    logic [BITS-1:0] shift_q;

    // Pad lines are active-low; store pressed as 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            shift_q <= '0;
            data    <= '0;
        end else begin
            sync_q <= {sync_q[0], serial};
            if (sample)
                shift_q[bit_idx] <= ~sync_q[1];
            if (load)
                data <= shift_q;
        end
    end

`ifdef SNES_EDGE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            press <= '0;
        else
            press <= load ? (shift_q & ~data) : '0;
    end
`endif

endmodule

// File: rtl/snes_multi_pad.sv
// Multi-pad SNES reader: shared latch/clock FSM and poll counter, one snes_pad_shift per pad.
// Optional macro SNES_EDGE_EN adds the press_pulse output.
module snes_multi_pad
    import snes_pkg::*;
#(
    parameter int NUM_PADS    = 2,
    parameter int BITS        = 16,
    parameter int HALF_TICKS  = 150,
    parameter int LATCH_TICKS = 300,
    parameter int POLL_TICKS  = 416750,
    parameter int CNT_W       = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     poll_en,
    input  logic [NUM_PADS-1:0]      serial_data,
    output logic                     snes_clk,
    output logic                     data_latch,
    output logic [NUM_PADS*BITS-1:0] button_data,
`ifdef SNES_EDGE_EN
    output logic [NUM_PADS*BITS-1:0] press_pulse,
`endif
    output logic                     frame_valid,
    output logic                     busy
);

    localparam int BIT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_TICKS - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_TICKS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS - 1);

    if (POLL_TICKS <= LATCH_TICKS + 2*HALF_TICKS*BITS + 1) begin : g_bad_poll
        $error("POLL_TICKS too short to hold one frame");
    end
    if (HALF_TICKS < 1 || LATCH_TICKS < 1) begin : g_bad_ticks
        $error("HALF_TICKS and LATCH_TICKS must be at least 1");
    end

    state_t           state;
    logic [CNT_W-1:0] poll_cnt;
    logic [CNT_W-1:0] phase;
    logic [BIT_W-1:0] bit_idx;
    logic             half_end;
    logic             sample;
    logic             load;

    assign half_end    = (phase == HALF_LAST);
    assign sample      = (state == LOW) && half_end;
    assign load        = (state == HIGH) && half_end && (bit_idx == BIT_LAST);
    assign snes_clk    = (state != LOW);
    assign data_latch  = (state == LATCH);
    assign frame_valid = (state == DONE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            poll_cnt <= '0;
        else
            poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
    end

    // A counter zero seen outside IDLE is simply ignored, never queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: if (poll_cnt == '0 && poll_en) begin
                    state <= LATCH;
                    phase <= '0;
                end
                LATCH: if (phase == LATCH_LAST) begin
                    state   <= LOW;
                    phase   <= '0;
                    bit_idx <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
                LOW: if (half_end) begin
                    state <= HIGH;
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
                HIGH: if (half_end) begin
                    phase <= '0;
                    if (bit_idx == BIT_LAST) begin
                        state <= DONE;
                    end else begin
                        state   <= LOW;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else begin
                    phase <= phase + 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output registers load on the edge into DONE, so new data lines up with frame_valid.
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        snes_pad_shift #(
            .BITS  (BITS),
            .BIT_W (BIT_W)
        ) u_pad (
            .clk     (clk),
            .reset   (reset),
            .serial  (serial_data[p]),
            .sample  (sample),
            .bit_idx (bit_idx),
            .load    (load),
`ifdef SNES_EDGE_EN
            .press   (press_pulse[p*BITS +: BITS]),
`endif
            .data    (button_data[p*BITS +: BITS])
        );
    end

endmodule
